uart_duplex: RTL

//  Parametrised full-duplex UART: ready/valid TX path and mid-bit-sampling RX path

---
 rtl/uart_duplex.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_duplex.sv
// Full-duplex UART: ready/valid transmitter and mid-bit sampling receiver on one clock.
// Data width, parity mode and stop-bit count are parameters; RX flags parity/framing errors.
module uart_duplex #(
  parameter int unsigned CLK_FREQ  = 12_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 TX,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned STOP_CLKS    = CLKS_PER_BIT * STOP_BITS;
  localparam int unsigned CNT_W        = $clog2(STOP_CLKS + 1);
  localparam int unsigned BIT_W        = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_CLKS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t            r_tx_state, w_tx_state_nxt;
  logic [CNT_W-1:0]     r_tx_cnt, w_tx_cnt_nxt;
  logic [BIT_W-1:0]     r_tx_bit, w_tx_bit_nxt;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
  logic                 r_tx_par, w_tx_par_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_tx_ready;
  logic                 w_tx_ready_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_ready <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_par   <= w_tx_par_nxt;
      r_tx       <= w_tx_nxt;
      r_tx_ready <= w_tx_ready_nxt;
    end
  end

  // Line level is computed for the next state so TX changes exactly on bit boundaries
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + CNT_W'(1);
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_par_nxt   = r_tx_par;
    w_tx_nxt       = r_tx;
    unique case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nxt = '0;
        w_tx_bit_nxt = '0;
        w_tx_nxt     = 1'b1;
        if (tx_valid) begin
          w_tx_state_nxt = TX_START;
          w_tx_shift_nxt = tx_data;
          w_tx_par_nxt   = (PARITY == 1) ? ~^tx_data : ^tx_data;
          w_tx_nxt       = 1'b0;
        end
      end
      TX_START: begin
        if (r_tx_cnt == BIT_END) begin
          w_tx_state_nxt = TX_DATA;
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
          w_tx_nxt       = r_tx_shift[0];
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == BIT_END) begin
          w_tx_cnt_nxt   = '0;
          w_tx_shift_nxt = r_tx_shift >> 1;
          if (r_tx_bit == LAST_BIT) begin
            w_tx_bit_nxt = '0;
            if (PARITY != 0) begin
              w_tx_state_nxt = TX_PARITY;
              w_tx_nxt       = r_tx_par;
            end else begin
              w_tx_state_nxt = TX_STOP;
              w_tx_nxt       = 1'b1;
            end
          end else begin
            w_tx_bit_nxt = r_tx_bit + BIT_W'(1);
            w_tx_nxt     = r_tx_shift[1];
          end
        end
      end
      TX_PARITY: begin
        if (r_tx_cnt == BIT_END) begin
          w_tx_state_nxt = TX_STOP;
          w_tx_cnt_nxt   = '0;
          w_tx_nxt       = 1'b1;
        end
      end
      TX_STOP: begin
        w_tx_nxt = 1'b1;
        if (r_tx_cnt == STOP_END) begin
          w_tx_state_nxt = TX_IDLE;
          w_tx_cnt_nxt   = '0;
        end
      end
      default: begin
        w_tx_state_nxt = TX_IDLE;
        w_tx_cnt_nxt   = '0;
        w_tx_nxt       = 1'b1;
      end
    endcase
    w_tx_ready_nxt = (w_tx_state_nxt == TX_IDLE);
  end

  assign TX       = r_tx;
  assign tx_ready = r_tx_ready;

  // ---------------- receiver ----------------
  logic                 r_rx_meta, r_rx_s;
  rx_state_t            r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0]     r_rx_cnt, w_rx_cnt_nxt;
  logic [BIT_W-1:0]     r_rx_bit, w_rx_bit_nxt;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
  logic                 r_rx_par, w_rx_par_nxt;
  logic                 w_rx_done;
  logic                 w_rx_perr;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_rx_perr, r_rx_ferr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_meta  <= RX;
      r_rx_s     <= r_rx_meta;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_par   <= w_rx_par_nxt;
      r_rx_valid <= w_rx_done;
      if (w_rx_done) begin
        r_rx_data <= r_rx_shift;
        r_rx_perr <= w_rx_perr;
        r_rx_ferr <= ~r_rx_s;
      end
    end
  end

  always_comb begin
    if (PARITY == 0) w_rx_perr = 1'b0;
    else             w_rx_perr = r_rx_par ^ ((PARITY == 1) ? ~^r_rx_shift : ^r_rx_shift);
  end

  // Start bit is qualified at half a bit; every later sample lands mid-bit
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt + CNT_W'(1);
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_par_nxt   = r_rx_par;
    w_rx_done      = 1'b0;
    unique case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        w_rx_bit_nxt = '0;
        if (!r_rx_s) w_rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (r_rx_cnt == HALF_END) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = r_rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BIT_END) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_s, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_bit == LAST_BIT) begin
            w_rx_bit_nxt   = '0;
            w_rx_state_nxt = (PARITY != 0) ? RX_PARITY : RX_STOP;
          end else begin
            w_rx_bit_nxt = r_rx_bit + BIT_W'(1);
          end
        end
      end
      RX_PARITY: begin
        if (r_rx_cnt == BIT_END) begin
          w_rx_cnt_nxt   = '0;
          w_rx_par_nxt   = r_rx_s;
          w_rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == BIT_END) begin
          w_rx_cnt_nxt   = '0;
          w_rx_done      = 1'b1;
          w_rx_state_nxt = r_rx_s ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_s) w_rx_state_nxt = RX_IDLE;
      end
      default: begin
        w_rx_state_nxt = RX_IDLE;
        w_rx_cnt_nxt   = '0;
      end
    endcase
  end

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_parity_err = r_rx_perr;
  assign rx_frame_err  = r_rx_ferr;

endmodule
